seg_display_scan: RTL and testbench
===================================

# seg_display_scan

Parametrised multiplexed seven-segment display driver for the Basys board I/O path. It accepts a signed or unsigned binary value through a load/busy handshake and converts it to BCD with an iterative double-dabble engine, one bit per cycle. It then scans the result across a configurable number of common-anode digits, with leading-zero blanking, a floating minus sign, per-digit decimal points and overflow indication. It supersedes the fixed 4-digit, 8-bit signed display driver.

## Interface
- `DIGITS`, 4: number of digits driven (2..8); digit 0 is rightmost.
- `WIDTH`, 8: input value width (4..20).
- `SIGNED`, 1: 1 = `din` is two's complement; 0 = unsigned.
- `REFRESH_DIV`, 1: clock cycles each digit stays lit (>=1).
- `BLANK_LZ`, 1: 1 = blank leading zeros; 0 = show them.

Ports:
- `disp_clk`  in  1  display clock; all state on rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `din`  in  WIDTH  value to display.
- `load`  in  1  request to capture `din`; accepted only when `busy`=0.
- `dp_mask`  in  DIGITS  decimal-point enables, bit i = digit i; sampled live.
- `busy`  out  1  conversion in progress.
- `overflow`  out  1  committed value does not fit in DIGITS.
- `anodes`  out  DIGITS  active-low digit enables, one-hot-low.
- `segment`  out  7  active-low cathodes {g,f,e,d,c,b,a}.
- `dp`  out  1  active-low decimal point for the lit digit.

## Operation
- Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, minus=0111111, blank=1111111.
- Internal BCD register width: `BCDN = (WIDTH*31)/100 + 1` nibbles, which always holds the full magnitude.
- FSM states:
  - IDLE: on `load`=1, capture `neg = SIGNED & din[WIDTH-1]` and `mag = neg ? -din : din` (WIDTH-bit unsigned, so the most negative value is exact). Clear BCD and go to CONV.
  - CONV: WIDTH iterations. Each adds 3 to every nibble >=5, then shifts `{bcd,mag}` left by 1. Go to COMMIT after the last iteration.
  - COMMIT: copy BCD and `neg` into the display registers and update `overflow`. Return to IDLE.
- Overflow rule: `avail = DIGITS - neg`. Overflow=1 if any BCD nibble at index >= `avail` is nonzero. On overflow, every digit shows minus; `dp` still follows `dp_mask`.
- Blanking (BLANK_LZ=1): nibbles above the most significant nonzero nibble are blank, and digit 0 is never blanked. When `neg`=1, minus goes in the digit just left of the most significant nonzero digit. Value 0 shows a single "0"; negative zero is impossible.
- BLANK_LZ=0: all digits show their nibble. When `neg`=1, digit DIGITS-1 shows minus.
- Scan: a prescaler counts 0..REFRESH_DIV-1. On wrap, the digit index advances i -> (i+1) mod DIGITS, explicitly wrapped for non-power-of-2 DIGITS. On the same edge, `anodes`, `segment` and `dp` are registered for the new index.
- `load` while `busy`=1 is ignored, with no queueing. `din` is sampled only on the accepting edge.

## Timing
- Reset (`rst_n`=0 at an edge): FSM→IDLE, `busy`=0, `overflow`=0, `anodes`=all 1, `segment`=1111111, `dp`=1, display value = +0, prescaler=0, index=DIGITS-1.
  - The first scan update after reset lights digit 0 with "0".
- Reset during CONV or COMMIT aborts the conversion; the display value returns to 0.
- Conversion handshake:
  - Accepting edge E0: `busy`=1 after E0.
  - Edges E1..E(WIDTH) run the iterations.
  - Edge E(WIDTH+1) commits; `busy`=0 after it.
  - `busy` is high for exactly WIDTH+1 cycles. A held `load` is next accepted at E(WIDTH+2).
- The new value appears on a digit at the first scan update after commit, at most `REFRESH_DIV` cycles later. No partially converted value is ever shown.
- Output latency: `anodes`, `segment` and `dp` change only on scan-update edges. `dp_mask` is sampled on those edges.

## Test plan
- Reset (DIGITS=4, WIDTH=8, REFRESH_DIV=1) -> outputs 1111/1111111/1 during reset. Then a 4-cycle anode rotation 1110,1101,1011,0111 with segments 1000000, blank, blank, blank.
- Load `din`=127 -> `busy` high 9 cycles. Then digit0=1111000, digit1=0100100, digit2=1111001, digit3 blank; `overflow`=0.
- Load `din`=8'h80 (-128) -> digits 3..0 = minus, 1, 2, 8. Load `din`=-5 -> digit1=minus, digit0=0010010, digits 2/3 blank.
- DIGITS=3, WIDTH=12:
  - `din`=999 -> shows 999, `overflow`=0.
  - `din`=1000 -> `overflow`=1, all three digits 0111111.
  - `din`=-99 -> shows minus, 9, 9.
  - `din`=-100 -> `overflow`=1.
- `load` held high continuously with `din` changing every cycle -> accepts occur exactly every WIDTH+2 cycles; each displayed value equals `din` at its accept edge.
- REFRESH_DIV=3, DIGITS=3, BLANK_LZ=0, `dp_mask`=3'b010, value 7 -> anodes 110,101,011 each held 3 cycles, segments 1111000, 1000000, 1000000, `dp`=0 only on digit1. Asserting `rst_n`=0 mid-CONV -> `busy`=0 next cycle and the display shows 000.

Source files
------------

// File: rtl/seg_display_scan.sv
`default_nettype none
// ============================================================================
//  Module   : seg_display_scan
//  Brief    : Multiplexed common-anode 7-segment driver with iterative
//             double-dabble BCD conversion, sign, blanking and overflow.
//  Revision : 1.0 - initial release
// ============================================================================

module seg_display_scan #(
    parameter int DIGITS      = 4,
    parameter int WIDTH       = 8,
    parameter int SIGNED      = 1,
    parameter int REFRESH_DIV = 1,
    parameter int BLANK_LZ    = 1
) (
    input  logic              disp_clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  din,
    input  logic              load,
    input  logic [DIGITS-1:0] dp_mask,
    output logic              busy,
    output logic              overflow,
    output logic [DIGITS-1:0] anodes,
    output logic [6:0]        segment,
    output logic              dp
);

    localparam int BCDN = (WIDTH * 31) / 100 + 1;
    localparam int BW   = 4 * BCDN;
    localparam int NIB  = (BCDN > DIGITS) ? BCDN : DIGITS;
    localparam int CW   = $clog2(WIDTH);
    localparam int IW   = $clog2(DIGITS);
    localparam int PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int NW   = $clog2(NIB + 1);

    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             neg_q, neg_d;
    logic [BW-1:0]    adj;
    logic             commit;
    logic             din_neg;
    logic             ovf_calc;

    logic [BW-1:0]     disp_bcd_q;
    logic              disp_neg_q;
    logic              ovf_q;
    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              scan_tick;
    logic [DIGITS-1:0] anodes_q, anodes_d;
    logic [6:0]        segment_q, seg_d;
    logic              dp_q;
    logic [4*NIB-1:0]  nib_ext;
    logic [NW-1:0]     msnz;
    logic [NW-1:0]     pos;
    logic [3:0]        cur_nib;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0011000;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

    assign din_neg = (SIGNED != 0) && din[WIDTH-1];

    // Add-3 correction on every BCD nibble before the shift
    always_comb begin
        adj = '0;
        for (int k = 0; k < BCDN; k++) begin
            adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3
                                                      : bcd_q[4*k +: 4];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    neg_d   = din_neg;
                    mag_d   = din_neg ? -din : din;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                bcd_d = BW'({adj, mag_q[WIDTH-1]});
                mag_d = {mag_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                commit  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The sign digit consumes one position, so the magnitude gets one fewer
    always_comb begin
        ovf_calc = 1'b0;
        for (int k = 0; k < BCDN; k++) begin
            if ((k >= DIGITS - (neg_q ? 1 : 0)) && (bcd_q[4*k +: 4] != 4'd0)) begin
                ovf_calc = 1'b1;
            end
        end
    end

    always_ff @(posedge disp_clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        scan_tick = (presc_q == PW'(REFRESH_DIV - 1));
        presc_d   = scan_tick ? '0 : presc_q + 1'b1;
        idx_d     = idx_q;
        if (scan_tick) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Digit decode for the index that becomes lit on the next scan edge
    always_comb begin
        nib_ext             = '0;
        nib_ext[BW-1:0]     = disp_bcd_q;
        msnz                = '0;
        for (int k = 0; k < BCDN; k++) begin
            if (disp_bcd_q[4*k +: 4] != 4'd0) begin
                msnz = NW'(k);
            end
        end
        pos     = NW'(idx_d);
        cur_nib = nib_ext[4*idx_d +: 4];
        seg_d   = seg_of(cur_nib);
        if (ovf_q) begin
            seg_d = SEG_MINUS;
        end else if (BLANK_LZ != 0) begin
            if (pos > msnz) begin
                seg_d = (disp_neg_q && (pos == msnz + 1'b1)) ? SEG_MINUS : SEG_BLANK;
            end
        end else if (disp_neg_q && (idx_d == IW'(DIGITS - 1))) begin
            seg_d = SEG_MINUS;
        end
        anodes_d = ~(DIGITS'(1) << idx_d);
    end

    always_ff @(posedge disp_clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            mag_q      <= '0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            disp_bcd_q <= '0;
            disp_neg_q <= 1'b0;
            ovf_q      <= 1'b0;
            presc_q    <= '0;
            idx_q      <= IW'(DIGITS - 1);
            anodes_q   <= '1;
            segment_q  <= SEG_BLANK;
            dp_q       <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            if (commit) begin
                disp_bcd_q <= bcd_q;
                disp_neg_q <= neg_q;
                ovf_q      <= ovf_calc;
            end
            if (scan_tick) begin
                anodes_q  <= anodes_d;
                segment_q <= seg_d;
                dp_q      <= ~dp_mask[idx_d];
            end
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign overflow = ovf_q;
    assign anodes   = anodes_q;
    assign segment  = segment_q;
    assign dp       = dp_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_display_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_display_scan
//  Brief    : Scoreboard bench for seg_display_scan over three configurations.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_seg_display_scan;

    localparam logic [6:0] S_MINUS = 7'b0111111;
    localparam logic [6:0] S_BLANK = 7'b1111111;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } scan_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // A: 4 digits, 8-bit signed, blanking. B: 3 digits, 12-bit. C: 3 digits, slow scan, no blanking.
    logic a_rst_n, a_load, a_busy, a_ovf, a_dp;
    logic [7:0] a_din;
    logic [3:0] a_dpm, a_an;
    logic [6:0] a_seg;
    logic b_rst_n, b_load, b_busy, b_ovf, b_dp;
    logic [11:0] b_din;
    logic [2:0] b_dpm, b_an;
    logic [6:0] b_seg;
    logic c_rst_n, c_load, c_busy, c_ovf, c_dp;
    logic [7:0] c_din;
    logic [2:0] c_dpm, c_an;
    logic [6:0] c_seg;

    seg_display_scan #(.DIGITS(4), .WIDTH(8), .SIGNED(1), .REFRESH_DIV(1), .BLANK_LZ(1)) u_a (
        .disp_clk(clk), .rst_n(a_rst_n), .din(a_din), .load(a_load), .dp_mask(a_dpm),
        .busy(a_busy), .overflow(a_ovf), .anodes(a_an), .segment(a_seg), .dp(a_dp));
    seg_display_scan #(.DIGITS(3), .WIDTH(12), .SIGNED(1), .REFRESH_DIV(1), .BLANK_LZ(1)) u_b (
        .disp_clk(clk), .rst_n(b_rst_n), .din(b_din), .load(b_load), .dp_mask(b_dpm),
        .busy(b_busy), .overflow(b_ovf), .anodes(b_an), .segment(b_seg), .dp(b_dp));
    seg_display_scan #(.DIGITS(3), .WIDTH(8), .SIGNED(1), .REFRESH_DIV(3), .BLANK_LZ(0)) u_c (
        .disp_clk(clk), .rst_n(c_rst_n), .din(c_din), .load(c_load), .dp_mask(c_dpm),
        .busy(c_busy), .overflow(c_ovf), .anodes(c_an), .segment(c_seg), .dp(c_dp));

    logic [7:0] o_an [3];
    logic [7:0] o_dpm[3];
    logic [6:0] o_seg[3];
    logic       o_dp [3];
    logic       o_busy[3];
    logic       o_ovf[3];
    assign o_an[0] = {4'hF, a_an};  assign o_an[1] = {5'h1F, b_an};  assign o_an[2] = {5'h1F, c_an};
    assign o_dpm[0] = {4'h0, a_dpm}; assign o_dpm[1] = {5'h00, b_dpm}; assign o_dpm[2] = {5'h00, c_dpm};
    assign o_seg[0] = a_seg;  assign o_seg[1] = b_seg;  assign o_seg[2] = c_seg;
    assign o_dp[0] = a_dp;    assign o_dp[1] = b_dp;    assign o_dp[2] = c_dp;
    assign o_busy[0] = a_busy; assign o_busy[1] = b_busy; assign o_busy[2] = c_busy;
    assign o_ovf[0] = a_ovf;  assign o_ovf[1] = b_ovf;  assign o_ovf[2] = c_ovf;

    int checks = 0;
    int failures = 0;
    scan_t exp_q[$];
    int acc_q[$];

    function automatic int ndig(int d); return (d == 0) ? 4 : 3; endfunction
    function automatic int wid(int d);  return (d == 1) ? 12 : 8; endfunction
    function automatic int rdiv(int d); return (d == 2) ? 3 : 1; endfunction
    function automatic bit blz(int d);  return d != 2; endfunction

    function automatic logic [6:0] digit_code(int n);
        case (n)
            0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
            3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
            9: return 7'b0011000;  default: return S_BLANK;
        endcase
    endfunction

    function automatic bit exp_ovf(int val, int nd);
        int mag;
        int lim;
        mag = (val < 0) ? -val : val;
        lim = 1;
        for (int k = 0; k < nd - ((val < 0) ? 1 : 0); k++) lim = lim * 10;
        return mag >= lim;
    endfunction

    // Decimal reference built with integer division, independent of double-dabble
    function automatic logic [6:0] exp_seg(int val, int nd, bit bl, int idx);
        int mag;
        int msd;
        int dec[8];
        bit neg;
        neg = val < 0;
        mag = neg ? -val : val;
        if (exp_ovf(val, nd)) return S_MINUS;
        msd = 0;
        for (int k = 0; k < 8; k++) begin
            dec[k] = mag % 10;
            if (dec[k] != 0) msd = k;
            mag = mag / 10;
        end
        if (bl) begin
            if (idx <= msd) return digit_code(dec[idx]);
            if (neg && idx == msd + 1) return S_MINUS;
            return S_BLANK;
        end
        if (neg && idx == nd - 1) return S_MINUS;
        return digit_code(dec[idx]);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(int d, int val, bit ld);
        logic [31:0] v;
        v = val;
        case (d)
            0:       begin a_din = v[7:0];  a_load = ld; end
            1:       begin b_din = v[11:0]; b_load = ld; end
            default: begin c_din = v[7:0];  c_load = ld; end
        endcase
    endtask

    task automatic load_value(int d, int val);
        int n;
        @(negedge clk);
        drive(d, val, 1'b1);
        @(negedge clk);
        drive(d, 0, 1'b0);
        n = 0;
        while (o_busy[d] === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check($sformatf("busy_len d%0d v%0d", d, val), n, wid(d) + 1);
    endtask

    task automatic check_display(int d, int val);
        logic [6:0] seen_seg[8];
        logic       seen_dp[8];
        bit         seen[8];
        scan_t      e;
        scan_t      o;
        for (int i = 0; i < ndig(d); i++) begin
            e.idx = 3'(i);
            e.an  = ~(8'd1 << i);
            e.seg = exp_seg(val, ndig(d), blz(d), i);
            e.dp  = ~o_dpm[d][i];
            exp_q.push_back(e);
            seen[i] = 1'b0;
        end
        check($sformatf("overflow d%0d v%0d", d, val), o_ovf[d], exp_ovf(val, ndig(d)));
        repeat (rdiv(d)) @(negedge clk);
        repeat (ndig(d) * rdiv(d)) begin
            for (int i = 0; i < ndig(d); i++) begin
                if (o_an[d] == ~(8'd1 << i)) begin
                    seen[i] = 1'b1;
                    seen_seg[i] = o_seg[d];
                    seen_dp[i] = o_dp[d];
                end
            end
            @(negedge clk);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o.idx = e.idx;
            o.an  = seen[e.idx] ? e.an : 8'h00;
            o.seg = seen_seg[e.idx];
            o.dp  = seen_dp[e.idx];
            check($sformatf("digit d%0d v%0d i%0d", d, val, e.idx), o, e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        scan_t e;
        scan_t o;
        int    n;
        int    first;
        int    prev_an;
        bit    prev_busy;
        int    last_rise;
        int    since;
        int    cur_val;
        int    v;
        logic [6:0] hs_seg[3];
        bit         hs_seen[3];

        a_rst_n = 0; b_rst_n = 0; c_rst_n = 0;
        a_load = 0; b_load = 0; c_load = 0;
        a_din = '0; b_din = '0; c_din = '0;
        a_dpm = 4'b0000; b_dpm = 3'b101; c_dpm = 3'b010;

        repeat (3) @(negedge clk);
        check("rst_anodes_a", o_an[0], 8'hFF);
        check("rst_seg_a", o_seg[0], S_BLANK);
        check("rst_dp_a", o_dp[0], 1'b1);
        check("rst_busy_a", o_busy[0], 1'b0);
        check("rst_ovf_a", o_ovf[0], 1'b0);
        check("rst_anodes_c", o_an[2], 8'hFF);

        // Post-reset rotation: "0" on digit 0, the rest blank
        exp_q.push_back('{3'd0, 8'hFE, 7'b1000000, 1'b1});
        exp_q.push_back('{3'd1, 8'hFD, S_BLANK, 1'b1});
        exp_q.push_back('{3'd2, 8'hFB, S_BLANK, 1'b1});
        exp_q.push_back('{3'd3, 8'hF7, S_BLANK, 1'b1});
        a_rst_n = 1; b_rst_n = 1; c_rst_n = 1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = '{e.idx, o_an[0], o_seg[0], o_dp[0]};
            check($sformatf("rst_rot i%0d", e.idx), o, e);
        end

        load_value(0, 127);   check_display(0, 127);
        load_value(0, -128);  check_display(0, -128);
        load_value(0, -5);    check_display(0, -5);

        load_value(1, 999);   check_display(1, 999);
        load_value(1, 1000);  check_display(1, 1000);
        load_value(1, -99);   check_display(1, -99);
        load_value(1, -100);  check_display(1, -100);

        // Held load on B: accepts every WIDTH+2 cycles, each value is din at accept
        @(negedge clk);
        prev_busy = o_busy[1];
        last_rise = -1;
        since = -1;
        cur_val = int'($urandom_range(0, 1098)) - 99;
        drive(1, cur_val, 1'b1);
        for (int c = 0; c < 76; c++) begin
            @(negedge clk);
            if (o_busy[1] && !prev_busy) begin
                acc_q.push_back(cur_val);
                if (last_rise >= 0) check("accept_spacing", c - last_rise, 14);
                last_rise = c;
            end
            if (!o_busy[1] && prev_busy) begin
                since = 0;
                for (int i = 0; i < 3; i++) hs_seen[i] = 1'b0;
            end else if (since >= 0 && since < 3) begin
                for (int i = 0; i < 3; i++) begin
                    if (o_an[1] == ~(8'd1 << i)) begin
                        hs_seen[i] = 1'b1;
                        hs_seg[i] = o_seg[1];
                    end
                end
                since++;
                if (since == 3) begin
                    check("held_queue_nonempty", acc_q.size() > 0, 1);
                    if (acc_q.size() > 0) begin
                        v = acc_q.pop_front();
                        check($sformatf("held_ovf v%0d", v), o_ovf[1], exp_ovf(v, 3));
                        for (int i = 0; i < 3; i++) begin
                            check($sformatf("held v%0d i%0d", v, i),
                                  hs_seen[i] ? {25'd0, hs_seg[i]} : 32'hFFFF_FFFF,
                                  {25'd0, exp_seg(v, 3, 1'b1, i)});
                        end
                    end
                end
            end
            prev_busy = o_busy[1];
            cur_val = int'($urandom_range(0, 1098)) - 99;
            drive(1, cur_val, 1'b1);
        end
        drive(1, 0, 1'b0);
        acc_q.delete();
        n = 0;
        while (o_busy[1] === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("held_drain", o_busy[1], 1'b0);

        // C: slow scan, no blanking, decimal point on digit 1
        load_value(2, 7);
        check_display(2, 7);
        prev_an = int'(o_an[2]);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (int'(o_an[2]) == prev_an && n < 10);
        check("c_align", (int'(o_an[2]) != prev_an) ? 1 : 0, 1);
        first = 0;
        for (int i = 0; i < 3; i++) if (o_an[2] == ~(8'd1 << i)) first = i;
        for (int k = 0; k < 9; k++) begin
            e.idx = 3'((first + k / 3) % 3);
            e.an  = ~(8'd1 << e.idx);
            e.seg = (e.idx == 3'd0) ? 7'b1111000 : 7'b1000000;
            e.dp  = (e.idx == 3'd1) ? 1'b0 : 1'b1;
            exp_q.push_back(e);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '{e.idx, o_an[2], o_seg[2], o_dp[2]};
            check($sformatf("c_hold i%0d", e.idx), o, e);
            @(negedge clk);
        end

        // Reset in the middle of a conversion
        drive(2, 123, 1'b1);
        @(negedge clk);
        drive(2, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("c_busy_mid_conv", o_busy[2], 1'b1);
        c_rst_n = 0;
        @(negedge clk);
        check("c_busy_after_rst", o_busy[2], 1'b0);
        check("c_anodes_after_rst", o_an[2], 8'hFF);
        c_rst_n = 1;
        check_display(2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
